// File: rtl/horn_trigger.sv
// Horn pushbutton front end: synchroniser, debounce and horn-enable FSM feeding the sawtooth DAC.
// Optional timeout lockout is compiled in with `define HORN_TIMEOUT_EN.
module horn_trigger #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BEEP_ON_CYCLES  = 12500000,
  parameter int unsigned BEEP_OFF_CYCLES = 12500000,
  parameter int unsigned MIN_ON_CYCLES   = 25000000,
  parameter int unsigned MAX_ON_CYCLES   = 1500000000
) (
  input  logic c50M,
  input  logic nReset,
  input  logic ButtonRaw,
  input  logic Cadence,
  output logic ButtonClean,
  output logic HornEnable,
  output logic Fault
);

  localparam int unsigned ST_MAX_A = (BEEP_ON_CYCLES > BEEP_OFF_CYCLES) ? BEEP_ON_CYCLES : BEEP_OFF_CYCLES;
  localparam int unsigned ST_MAX   = (MIN_ON_CYCLES > ST_MAX_A) ? MIN_ON_CYCLES : ST_MAX_A;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(ST_MAX) + 1;

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ON_LAST  = ST_W'(BEEP_ON_CYCLES - 1);
  localparam logic [ST_W-1:0] OFF_LAST = ST_W'(BEEP_OFF_CYCLES - 1);
  localparam logic [ST_W-1:0] MIN_LAST = ST_W'(MIN_ON_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SOUND, GAP, LOCKOUT} state_t;

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            clean_q;
  state_t          state_q, state_d;
  logic            mode_q;
  logic [ST_W-1:0] timer_q;
  logic            horn_q;

  always_ff @(posedge c50M) begin
    if (!nReset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
      clean_q  <= 1'b0;
    end else begin
      sync1_q <= ButtonRaw;
      sync2_q <= sync1_q;
      if (sync2_q == clean_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        clean_q  <= ~clean_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

`ifdef HORN_TIMEOUT_EN
  localparam int TT_W = $clog2(MAX_ON_CYCLES) + 1;
  localparam logic [TT_W-1:0] TT_LAST = TT_W'(MAX_ON_CYCLES - 1);

  logic [TT_W-1:0] total_q;
  logic            fault_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clean_q) state_d = SOUND;
      end
      SOUND: begin
        // Pulsed beeps always run to completion; the level at expiry picks GAP or IDLE.
        if (mode_q) begin
          if (timer_q == ON_LAST) state_d = clean_q ? GAP : IDLE;
        end else if (!clean_q && (timer_q >= MIN_LAST)) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (!clean_q)                 state_d = IDLE;
        else if (timer_q == OFF_LAST) state_d = SOUND;
      end
`ifdef HORN_TIMEOUT_EN
      LOCKOUT: begin
        if (!clean_q) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef HORN_TIMEOUT_EN
    if (((state_q == SOUND) || (state_q == GAP)) && (total_q == TT_LAST)) state_d = LOCKOUT;
`endif
  end

  always_ff @(posedge c50M) begin
    if (!nReset) begin
      state_q <= IDLE;
      timer_q <= '0;
      mode_q  <= 1'b0;
      horn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)  timer_q <= '0;
      else if (timer_q != '1)  timer_q <= timer_q + ST_W'(1);
      if ((state_q == IDLE) && (state_d == SOUND)) mode_q <= Cadence;
      horn_q <= (state_d == SOUND);
    end
  end

`ifdef HORN_TIMEOUT_EN
  always_ff @(posedge c50M) begin
    if (!nReset) begin
      total_q <= '0;
      fault_q <= 1'b0;
    end else begin
      // Held at zero while idle, so every activation starts its budget afresh.
      if (state_q == IDLE)
        total_q <= '0;
      else if (((state_q == SOUND) || (state_q == GAP)) && (total_q != '1))
        total_q <= total_q + TT_W'(1);
      fault_q <= (state_d == LOCKOUT);
    end
  end

  assign Fault = fault_q;
`else
  assign Fault = 1'b0;
`endif

  assign ButtonClean = clean_q;
  assign HornEnable  = horn_q;

endmodule

// File: tb/tb_horn_trigger.sv
// Directed bench for horn_trigger with small timing parameters; table vectors plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_horn_trigger;

  logic clk = 1'b0;
  logic nReset, ButtonRaw, Cadence;
  logic ButtonClean, HornEnable, Fault;

  int n_cmp  = 0;
  int n_fail = 0;

  logic rec_horn  [0:199];
  logic rec_clean [0:199];
  logic rec_fault [0:199];

  typedef struct {
    logic nrst;
    logic raw;
    logic cad;
    logic e_clean;
    logic e_horn;
    logic e_fault;
  } vec_t;

  vec_t vq[$];

  horn_trigger #(
    .DEBOUNCE_CYCLES(4),
    .BEEP_ON_CYCLES (8),
    .BEEP_OFF_CYCLES(4),
    .MIN_ON_CYCLES  (16),
    .MAX_ON_CYCLES  (64)
  ) dut (
    .c50M       (clk),
    .nReset     (nReset),
    .ButtonRaw  (ButtonRaw),
    .Cadence    (Cadence),
    .ButtonClean(ButtonClean),
    .HornEnable (HornEnable),
    .Fault      (Fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic step(input logic nrst, input logic raw, input logic cad);
    nReset    = nrst;
    ButtonRaw = raw;
    Cadence   = cad;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Raw held high for n_raw steps; Cadence flips at flip_at; nReset pulses low at rst_at.
  task automatic run_seq(input int n_raw, input int n_total, input logic cad0,
                         input int flip_at, input int rst_at);
    for (int i = 0; i < n_total; i++) begin
      step((i == rst_at) ? 1'b0 : 1'b1,
           (i < n_raw) ? 1'b1 : 1'b0,
           (flip_at >= 0 && i >= flip_at) ? ~cad0 : cad0);
      rec_horn[i]  = HornEnable;
      rec_clean[i] = ButtonClean;
      rec_fault[i] = Fault;
    end
  endtask

  function automatic int count_horn(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (rec_horn[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_fault(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (rec_fault[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_rises(input int n);
    int c = 0;
    for (int i = 1; i < n; i++) if (rec_horn[i] === 1'b1 && rec_horn[i-1] === 1'b0) c++;
    return c;
  endfunction

  initial begin
    nReset = 1'b0; ButtonRaw = 1'b0; Cadence = 1'b0;

    // Reset with button held, then release: clean after 6th edge, horn after 7th.
    for (int i = 0; i < 3; i++) vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    // Reset mid-sound, then a 3-cycle glitch that must not pass the debouncer.
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    foreach (vq[v]) begin
      step(vq[v].nrst, vq[v].raw, vq[v].cad);
      check($sformatf("vec%0d clean", v), 32'(ButtonClean), 32'(vq[v].e_clean));
      check($sformatf("vec%0d horn", v),  32'(HornEnable),  32'(vq[v].e_horn));
      check($sformatf("vec%0d fault", v), 32'(Fault),       32'(vq[v].e_fault));
    end

    // After the glitch the counter must be clear: a real press takes the full latency.
    run_seq(8, 8, 1'b0, -1, -1);
    check("post_glitch clean idx4", 32'(rec_clean[4]), 32'd0);
    check("post_glitch clean idx5", 32'(rec_clean[5]), 32'd1);

    // Continuous mode: short press stretched to 16, long press follows the button.
    do_reset();
    run_seq(6, 40, 1'b0, -1, -1);
    check("cont short horn cycles", 32'(count_horn(40)), 32'd16);
    check("cont short horn pulses", 32'(count_rises(40)), 32'd1);
    check("cont short horn idx6", 32'(rec_horn[6]), 32'd1);
    check("cont short horn idx5", 32'(rec_horn[5]), 32'd0);
    do_reset();
    run_seq(30, 60, 1'b0, -1, -1);
    check("cont long horn cycles", 32'(count_horn(60)), 32'd30);
    check("cont long horn pulses", 32'(count_rises(60)), 32'd1);

    // Pulsed mode: 8 on / 4 off, last beep completes, Cadence flip ignored.
    do_reset();
    run_seq(40, 64, 1'b1, 20, -1);
    for (int i = 0; i < 64; i++) begin
      automatic logic exp_h = (i >= 6) && ((i - 6) < 48) && (((i - 6) % 12) < 8);
      check($sformatf("cadence horn idx%0d", i), 32'(rec_horn[i]), 32'(exp_h));
    end

    // Reset during the 5th beep cycle with button held: full debounce before restart.
    do_reset();
    run_seq(24, 24, 1'b1, -1, 10);
    check("rst_mid horn idx9",   32'(rec_horn[9]),   32'd1);
    check("rst_mid horn idx10",  32'(rec_horn[10]),  32'd0);
    check("rst_mid clean idx10", 32'(rec_clean[10]), 32'd0);
    check("rst_mid clean idx15", 32'(rec_clean[15]), 32'd0);
    check("rst_mid clean idx16", 32'(rec_clean[16]), 32'd1);
    check("rst_mid horn idx16",  32'(rec_horn[16]),  32'd0);
    check("rst_mid horn idx17",  32'(rec_horn[17]),  32'd1);

    // Long hold in continuous mode: lockout when compiled in, endless sound otherwise.
    do_reset();
    run_seq(100, 120, 1'b0, -1, -1);
`ifdef HORN_TIMEOUT_EN
    check("timeout horn cycles",  32'(count_horn(120)),  32'd64);
    check("timeout horn idx69",   32'(rec_horn[69]),     32'd1);
    check("timeout horn idx70",   32'(rec_horn[70]),     32'd0);
    check("timeout fault idx70",  32'(rec_fault[70]),    32'd1);
    check("timeout fault idx105", 32'(rec_fault[105]),   32'd1);
    check("timeout fault idx106", 32'(rec_fault[106]),   32'd0);
    check("timeout fault cycles", 32'(count_fault(120)), 32'd36);
`else
    check("hold horn cycles",  32'(count_horn(120)),  32'd100);
    check("hold horn idx105",  32'(rec_horn[105]),    32'd1);
    check("hold horn idx106",  32'(rec_horn[106]),    32'd0);
    check("hold fault cycles", 32'(count_fault(120)), 32'd0);
`endif
    check("hold clean idx104", 32'(rec_clean[104]), 32'd1);
    check("hold clean idx105", 32'(rec_clean[105]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
